// File: rtl/memory_arbiter.sv
// memory_arbiter: two-requester front end for a simple dual-port memory
// (one registered read port, one write port). Reads and writes are arbitrated
// independently, each round-robin, so one read and one write may complete in
// the same cycle. Read data returns one cycle after acceptance, tagged to the
// requester that owns it.
//
// Optional feature macro: MEM_ARB_BYPASS_EN
//   defined   - a same-cycle read and write to the same address returns the
//               newly written data (write-to-read forwarding).
//   undefined - read data is always the memory output (read-before-write).
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [DATA_WIDTH-1:0]    a_rdata,

    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_wdata,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [DATA_WIDTH-1:0]    b_rdata,

    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [ADDRESS_WIDTH-1:0] mem_rdaddr,
    output logic [ADDRESS_WIDTH-1:0] mem_wraddr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

    // Per-type request qualifiers, forced low during reset so no grant escapes.
    logic a_rd_req, b_rd_req, a_wr_req, b_wr_req;
    logic a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;

    // 1 = B won the most recent arbitration of that type.
    logic last_rd_b, last_wr_b;

    // Read ownership of the data coming back from memory next cycle.
    logic a_rv_q, b_rv_q;

    logic [DATA_WIDTH-1:0] rd_data;

    // Split requests by type and pick winners; in contention the previous loser wins.
    always_comb begin
        a_rd_req = a_req & ~a_we & ~rst;
        b_rd_req = b_req & ~b_we & ~rst;
        a_wr_req = a_req &  a_we & ~rst;
        b_wr_req = b_req &  b_we & ~rst;

        a_rd_gnt = a_rd_req & (~b_rd_req |  last_rd_b);
        b_rd_gnt = b_rd_req & (~a_rd_req | ~last_rd_b);
        a_wr_gnt = a_wr_req & (~b_wr_req |  last_wr_b);
        b_wr_gnt = b_wr_req & (~a_wr_req | ~last_wr_b);

        a_gnt = a_rd_gnt | a_wr_gnt;
        b_gnt = b_rd_gnt | b_wr_gnt;
    end

    // Steer the winning command onto the memory ports; idle ports drive zero.
    always_comb begin
        mem_rd     = a_rd_gnt | b_rd_gnt;
        mem_wr     = a_wr_gnt | b_wr_gnt;
        mem_rdaddr = '0;
        mem_wraddr = '0;
        mem_dataIn = '0;
        if (a_rd_gnt) begin
            mem_rdaddr = a_addr;
        end else if (b_rd_gnt) begin
            mem_rdaddr = b_addr;
        end
        if (a_wr_gnt) begin
            mem_wraddr = a_addr;
            mem_dataIn = a_wdata;
        end else if (b_wr_gnt) begin
            mem_wraddr = b_addr;
            mem_dataIn = b_wdata;
        end
    end

    // Remember who won each type; hold when that type sees no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd_b <= 1'b1;
            last_wr_b <= 1'b1;
        end else begin
            if (a_rd_gnt | b_rd_gnt) begin
                last_rd_b <= b_rd_gnt;
            end
            if (a_wr_gnt | b_wr_gnt) begin
                last_wr_b <= b_wr_gnt;
            end
        end
    end

    // Tag the read accepted this cycle so its data returns to the right owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rv_q <= 1'b0;
            b_rv_q <= 1'b0;
        end else begin
            a_rv_q <= a_rd_gnt;
            b_rv_q <= b_rd_gnt;
        end
    end

`ifdef MEM_ARB_BYPASS_EN
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    // Capture write data when a read and write hit the same address together.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            hit_q <= mem_rd & mem_wr & (mem_rdaddr == mem_wraddr);
            if (mem_rd & mem_wr & (mem_rdaddr == mem_wraddr)) begin
                byp_data_q <= mem_dataIn;
            end
        end
    end

    // Forwarded write data overrides the stale memory output after a collision.
    always_comb begin
        rd_data = hit_q ? byp_data_q : mem_dataOut;
    end
`else
    // Memory output as-is: a colliding read sees the old contents.
    always_comb begin
        rd_data = mem_dataOut;
    end
`endif

    // Return data to both requesters; valid is suppressed while in reset so a
    // read accepted just before reset never reports.
    always_comb begin
        a_rvalid = a_rv_q & ~rst;
        b_rvalid = b_rv_q & ~rst;
        a_rdata  = rd_data;
        b_rdata  = rd_data;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and memory contents.
module tb_memory_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_rdaddr, mem_wraddr;
    logic [DW-1:0] mem_dataIn, mem_dataOut;

    int errors = 0;
    int checks = 0;

    // Behavioural memory: registered read port, write port, preload port.
    logic [DW-1:0] tbmem [0:255];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_dataOut <= tbmem[mem_rdaddr];
        if (mem_wr) tbmem[mem_wraddr] <= mem_dataIn;
        if (pl_en)  tbmem[pl_addr] <= pl_data;
    end

    memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdaddr(mem_rdaddr),
        .mem_wraddr(mem_wraddr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        pl_en = 1; pl_addr = addr; pl_data = data;
        tick();
        pl_en = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        a_req = 1; b_req = 1; a_we = 0; b_we = 1;
        a_addr = 8'h01; b_addr = 8'h02; a_wdata = 32'h11; b_wdata = 32'h22;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({a_gnt, b_gnt, mem_rd, mem_wr, a_rvalid, b_rvalid} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got gnt=%b%b rd=%b wr=%b rv=%b%b, need all 0",
                         i, a_gnt, b_gnt, mem_rd, mem_wr, a_rvalid, b_rvalid);
            end
            tick();
        end
        rst = 0;
        idle();
    endtask

    task automatic test_write_read();
        a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_wraddr !== 8'h10 || mem_dataIn !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_grant: got gnt=%b wr=%b addr=%h data=%h, need 1 1 10 deadbeef",
                     a_gnt, mem_wr, mem_wraddr, mem_dataIn);
        end
        tick();
        a_we = 0;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || mem_rd !== 1'b1 || mem_rdaddr !== 8'h10 || mem_wr !== 1'b0 || mem_wraddr !== 8'h00) begin
            errors++;
            $display("FAIL rd_grant: got gnt=%b rd=%b rdaddr=%h wr=%b wraddr=%h, need 1 1 10 0 00",
                     a_gnt, mem_rd, mem_rdaddr, mem_wr, mem_wraddr);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_return: got a_rv=%b a_rdata=%h b_rv=%b, need 1 deadbeef 0",
                     a_rvalid, a_rdata, b_rvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_single: got a_rv=%b, need 0", a_rvalid);
        end
        tick();
    endtask

    task automatic test_read_alternate();
        preload(8'h40, 32'hAAAA0040);
        preload(8'h41, 32'hBBBB0041);
        do_reset();
        a_req = 1; a_we = 0; a_addr = 8'h40;
        b_req = 1; b_we = 0; b_addr = 8'h41;
        for (int k = 0; k <= 4; k++) begin
            if (k == 4) idle();
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (a_gnt !== (k % 2 == 0) || b_gnt !== (k % 2 == 1)) begin
                    errors++;
                    $display("FAIL alt_grant cycle %0d: got a=%b b=%b, need a=%0d b=%0d",
                             k, a_gnt, b_gnt, k % 2 == 0, k % 2 == 1);
                end
            end
            if (k > 0) begin
                checks++;
                if (a_rvalid !== ((k - 1) % 2 == 0) || b_rvalid !== ((k - 1) % 2 == 1) ||
                    a_rdata !== (((k - 1) % 2 == 0) ? 32'hAAAA0040 : 32'hBBBB0041)) begin
                    errors++;
                    $display("FAIL alt_return cycle %0d: got a_rv=%b b_rv=%b data=%h",
                             k, a_rvalid, b_rvalid, a_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_mixed();
        preload(8'h21, 32'h7);
        a_req = 1; a_we = 1; a_addr = 8'h20; a_wdata = 32'h5;
        b_req = 1; b_we = 0; b_addr = 8'h21;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b1 || mem_rdaddr !== 8'h21 || mem_wraddr !== 8'h20) begin
            errors++;
            $display("FAIL mixed_grant: got a=%b b=%b rdaddr=%h wraddr=%h, need 1 1 21 20",
                     a_gnt, b_gnt, mem_rdaddr, mem_wraddr);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h7 || a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mixed_return: got b_rv=%b b_rdata=%h a_rv=%b, need 1 7 0",
                     b_rvalid, b_rdata, a_rvalid);
        end
        tick();
    endtask

    task automatic test_collision();
        logic [DW-1:0] exp_data;
`ifdef MEM_ARB_BYPASS_EN
        exp_data = 32'h9;
`else
        exp_data = 32'h1;
`endif
        preload(8'h30, 32'h1);
        preload(8'h31, 32'h33);
        a_req = 1; a_we = 1; a_addr = 8'h30; a_wdata = 32'h9;
        b_req = 1; b_we = 0; b_addr = 8'h30;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b1) begin
            errors++;
            $display("FAIL coll_grant: got a=%b b=%b, need 1 1", a_gnt, b_gnt);
        end
        tick();
        idle();
        b_req = 1; b_addr = 8'h31;
        @(negedge clk);
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== exp_data) begin
            errors++;
            $display("FAIL coll_return: got rv=%b data=%h, need 1 %h", b_rvalid, b_rdata, exp_data);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'h33) begin
            errors++;
            $display("FAIL coll_after: got rv=%b data=%h, need 1 00000033", b_rvalid, b_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        a_req = 1; a_we = 0; a_addr = 8'h40;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_accept: got gnt=%b, need 1", a_gnt);
        end
        tick();
        idle();
        rst = 1;
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rvalid: got a_rv=%b b_rv=%b, need 0 0", a_rvalid, b_rvalid);
        end
        tick();
        tick();
        rst = 0;
        a_req = 1; a_we = 0; a_addr = 8'h40;
        b_req = 1; b_we = 0; b_addr = 8'h41;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_rd: got a=%b b=%b, need 1 0", a_gnt, b_gnt);
        end
        tick();
        a_we = 1; b_we = 1; a_addr = 8'h50; b_addr = 8'h51;
        a_wdata = 32'h50; b_wdata = 32'h51;
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_wraddr !== 8'h50 || mem_dataIn !== 32'h50) begin
            errors++;
            $display("FAIL post_rst_wr: got a=%b b=%b wraddr=%h data=%h, need 1 0 50 00000050",
                     a_gnt, b_gnt, mem_wraddr, mem_dataIn);
        end
        tick();
        idle();
        tick();
    endtask

    // Randomized traffic against a transaction-level model.
    task automatic test_random();
        logic [DW-1:0] ref_mem [0:255];
        int            last_rd_winner, last_wr_winner;   // 0 = A, 1 = B
        bit            a_pend, b_pend;
        bit            pv_a, pv_b;
        logic [DW-1:0] pv_data;
        bit            ea_gnt, eb_gnt, e_rd, e_wr;
        int            rd_who, wr_who;
        logic [AW-1:0] e_rdaddr, e_wraddr;
        logic [DW-1:0] e_din, e_rdata;
        bit            readers [2];
        bit            writers [2];
        logic [AW-1:0] addr [2];
        logic [DW-1:0] wd [2];

        for (int i = 0; i < 4; i++) begin
            preload(8'h80 + 8'(i), 32'hC0DE0000 + i);
            ref_mem[8'h80 + i] = 32'hC0DE0000 + i;
        end
        do_reset();
        last_rd_winner = 1; last_wr_winner = 1;
        a_pend = 0; b_pend = 0; pv_a = 0; pv_b = 0; pv_data = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!a_pend) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_we = 1'($urandom_range(0, 1));
                a_addr = 8'h80 + 8'($urandom_range(0, 3));
                a_wdata = $urandom;
            end
            if (!b_pend) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_we = 1'($urandom_range(0, 1));
                b_addr = 8'h80 + 8'($urandom_range(0, 3));
                b_wdata = $urandom;
            end
            readers[0] = a_req && !a_we; readers[1] = b_req && !b_we;
            writers[0] = a_req && a_we;  writers[1] = b_req && b_we;
            addr[0] = a_addr; addr[1] = b_addr;
            wd[0] = a_wdata;  wd[1] = b_wdata;

            rd_who = -1;
            if (readers[0] && readers[1]) rd_who = 1 - last_rd_winner;
            else if (readers[0])          rd_who = 0;
            else if (readers[1])          rd_who = 1;
            wr_who = -1;
            if (writers[0] && writers[1]) wr_who = 1 - last_wr_winner;
            else if (writers[0])          wr_who = 0;
            else if (writers[1])          wr_who = 1;

            ea_gnt = (rd_who == 0) || (wr_who == 0);
            eb_gnt = (rd_who == 1) || (wr_who == 1);
            e_rd = (rd_who >= 0);
            e_wr = (wr_who >= 0);
            e_rdaddr = e_rd ? addr[rd_who] : '0;
            e_wraddr = e_wr ? addr[wr_who] : '0;
            e_din    = e_wr ? wd[wr_who] : '0;

            @(negedge clk);
            checks++;
            if (a_gnt !== ea_gnt || b_gnt !== eb_gnt || mem_rd !== e_rd || mem_wr !== e_wr ||
                mem_rdaddr !== e_rdaddr || mem_wraddr !== e_wraddr || mem_dataIn !== e_din) begin
                errors++;
                $display("FAIL rand_cmd cycle %0d: got gnt=%b%b rd=%b wr=%b ra=%h wa=%h di=%h, need gnt=%b%b rd=%b wr=%b ra=%h wa=%h di=%h",
                         cyc, a_gnt, b_gnt, mem_rd, mem_wr, mem_rdaddr, mem_wraddr, mem_dataIn,
                         ea_gnt, eb_gnt, e_rd, e_wr, e_rdaddr, e_wraddr, e_din);
            end
            checks++;
            if (a_rvalid !== pv_a || b_rvalid !== pv_b ||
                ((pv_a || pv_b) && a_rdata !== pv_data)) begin
                errors++;
                $display("FAIL rand_ret cycle %0d: got rv=%b%b data=%h, need rv=%b%b data=%h",
                         cyc, a_rvalid, b_rvalid, a_rdata, pv_a, pv_b, pv_data);
            end

            pv_a = (rd_who == 0);
            pv_b = (rd_who == 1);
            if (e_rd) begin
                e_rdata = ref_mem[e_rdaddr];
`ifdef MEM_ARB_BYPASS_EN
                if (e_wr && e_wraddr == e_rdaddr) e_rdata = e_din;
`endif
                pv_data = e_rdata;
            end
            if (e_wr) ref_mem[e_wraddr] = e_din;
            if (rd_who >= 0) last_rd_winner = rd_who;
            if (wr_who >= 0) last_wr_winner = wr_who;
            a_pend = a_req && !ea_gnt;
            b_pend = b_req && !eb_gnt;
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_write_read();
        test_read_alternate();
        test_mixed();
        test_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
